pcileech_eth_tx_aggr: RTL and testbench
=======================================

PCILEECH_ETH_TX_AGGR -- requirements
Module: pcileech_eth_tx_aggr

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256, meaning the maximum number of payload words per burst (power of two, 2..256).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning the idle cycles after the last accepted word before a partial burst flushes (10 us at 100 MHz).
REQ-003 SHALL have parameter HDR_MAGIC, default 16'hE7A0, meaning the upper half of the header word.
REQ-004 clk  input  1  system clock, 100 MHz; the only clock.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 s_data  input  32  payload word from the upstream 32-bit FIFO stage.
REQ-007 s_valid  input  1  s_data valid.
REQ-008 s_ready  output  1  block accepts s_data this cycle.
REQ-009 m_data  output  32  framed word towards the Ethernet/UDP transmitter.
REQ-010 m_valid  output  1  m_data valid.
REQ-011 m_ready  input  1  transmitter accepts m_data this cycle.
REQ-012 m_last  output  1  m_data is the final word of a burst.
REQ-013 busy  output  1  high in every state except IDLE; drives an activity LED.

Function
REQ-014 A transfer on either port SHALL occur only on a rising clk edge where valid and ready are both high.
REQ-015 The state machine SHALL have the states IDLE, FILL, HDR, DRAIN and TRAIL.
REQ-016 IDLE SHALL assert s_ready and SHALL go to FILL on the first accepted word, writing that word to buffer address 0.
REQ-017 FILL SHALL assert s_ready, write each accepted word at address cnt, and increment cnt (9 bits).
REQ-018 FILL SHALL go to HDR on the cycle cnt reaches MAX_WORDS, deasserting s_ready in that same cycle.
REQ-019 FILL SHALL go to HDR when the idle counter reaches TIMEOUT_CYCLES; the idle counter SHALL clear on every accepted word.
REQ-020 When a timeout and an accepted word coincide, the word SHALL be accepted and the counter cleared; no flush occurs that cycle.
REQ-021 HDR SHALL present m_data = {HDR_MAGIC, cnt[15:0]} with s_ready low, and SHALL go to DRAIN on the header transfer.
REQ-022 DRAIN SHALL present the buffer words in address order, sustaining one word per cycle while m_ready is high.
REQ-023 Any bubble SHALL occur only on the first payload word of DRAIN.
REQ-024 m_data and m_valid SHALL hold stable while m_valid is high and m_ready is low.
REQ-025 After the word at address cnt-1 transfers, DRAIN SHALL go to TRAIL when the trailer is enabled (see Configuration) and otherwise to IDLE, clearing cnt.
REQ-026 m_last SHALL be high only with the final word of the burst (trailer if enabled, else last payload word).
REQ-027 The block SHALL never emit a burst with cnt = 0, and s_ready SHALL be low in HDR, DRAIN and TRAIL.

Reset
REQ-028 On rst_n low, the block SHALL enter IDLE with s_ready=0, m_valid=0, m_last=0, m_data=0, busy=0, cnt=0, idle counter=0 and XOR accumulator=0.
REQ-029 s_ready SHALL rise the first cycle after rst_n deasserts.
REQ-030 Assertion mid-burst SHALL discard buffered data with no partial output; buffer RAM contents need no reset.

Configuration
REQ-031 With macro PCILEECH_ETH_TX_AGGR_TRAILER_EN defined, a TRAIL word equal to the XOR of the header and all payload words SHALL follow DRAIN, with m_last set.
REQ-032 Without PCILEECH_ETH_TX_AGGR_TRAILER_EN, TRAIL and the XOR accumulator SHALL not exist, and m_last SHALL be on the last payload word.

Structure
REQ-033 The state enum, HDR_MAGIC default and header field widths SHALL live in shared package pcileech_eth_pkg.
REQ-034 The buffer SHALL be sub-module pcileech_eth_tx_aggr_ram: MAX_WORDS x 32 simple dual-port RAM, one write port, one read port with 1-cycle registered read latency.

Verification
REQ-035 The bench SHALL feed 256 words 0x00000001..0x00000100 back-to-back with m_ready=1, expecting header 0xE7A00100, the 256 words in order, and m_last on word 0x100 (trailer off).
REQ-036 The bench SHALL feed 3 words, then idle 1000 cycles, expecting a flush with header 0xE7A00003, then the 3 words.
REQ-037 The bench SHALL feed one word every 999 cycles for 10 words, expecting no flush until 1000 cycles after the 10th word and a header count of 10.
REQ-038 The bench SHALL toggle m_ready randomly at 50% during DRAIN, expecting m_data stable while stalled and no lost or duplicated words.
REQ-039 The bench SHALL pulse rst_n low mid-DRAIN, expecting m_valid=0 immediately and, after release, the next burst to start with a fresh header and correct count.
REQ-040 With TRAILER_EN, the bench SHALL send words 0x1, 0x2 and 0x4 and time out, expecting trailer 0xE7A00003^0x7 = 0xE7A00004 with m_last.

Source files
------------

// File: rtl/pcileech_eth_pkg.sv
// rtl/pcileech_eth_pkg.sv - shared types and header layout for the Ethernet TX aggregator
package pcileech_eth_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_HDR,
    S_DRAIN,
    S_TRAIL
  } state_t;

  localparam int HDR_MAGIC_W = 16;
  localparam int HDR_CNT_W   = 16;
  localparam int CNT_W       = 9;

  localparam logic [HDR_MAGIC_W-1:0] HDR_MAGIC_DEFAULT = 16'hE7A0;

  function automatic logic [31:0] make_hdr(input logic [HDR_MAGIC_W-1:0] magic,
                                           input logic [CNT_W-1:0]       cnt);
    return {magic, {(HDR_CNT_W - CNT_W){1'b0}}, cnt};
  endfunction

endpackage

// File: rtl/pcileech_eth_tx_aggr_ram.sv
// rtl/pcileech_eth_tx_aggr_ram.sv - burst buffer, simple dual-port RAM with registered read
module pcileech_eth_tx_aggr_ram #(
  parameter int DEPTH = 256,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pcileech_eth_tx_aggr.sv
// rtl/pcileech_eth_tx_aggr.sv - aggregates 32-bit words into header-prefixed bursts
// Optional XOR trailer word: define PCILEECH_ETH_TX_AGGR_TRAILER_EN.
module pcileech_eth_tx_aggr
  import pcileech_eth_pkg::*;
#(
  parameter int                     MAX_WORDS      = 256,
  parameter int                     TIMEOUT_CYCLES = 1000,
  parameter logic [HDR_MAGIC_W-1:0] HDR_MAGIC      = HDR_MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy
);

  localparam int AW = $clog2(MAX_WORDS);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PCILEECH_ETH_TX_AGGR_TRAILER_EN
  localparam bit TRAILER_EN = 1'b1;
  logic [31:0] xacc;
`else
  localparam bit TRAILER_EN = 1'b0;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] out_idx;
  logic [AW-1:0]    pf;
  logic [IW-1:0]    idle_cnt;

  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_dec;
  logic [CNT_W-1:0] out_idx_inc;
  logic             s_acc;
  logic             m_xfer;
  logic             fill_full;
  logic             fill_tmo;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [31:0]      rd_q;

  assign cnt_inc     = cnt + CNT_W'(1);
  assign cnt_dec     = cnt - CNT_W'(1);
  assign out_idx_inc = out_idx + CNT_W'(1);
  assign s_acc       = s_valid && s_ready;
  assign m_xfer      = m_valid && m_ready;
  assign fill_full   = (state == S_FILL) && s_acc && (cnt_inc == CNT_W'(MAX_WORDS));
  assign fill_tmo    = (state == S_FILL) && !s_acc && (idle_cnt == IW'(TIMEOUT_CYCLES - 1));
  assign busy        = (state != S_IDLE);

  // Word 0 is prefetched as the burst closes, so rd_q always holds the next word to present
  // and stays put while the output is stalled.
  assign rd_en   = fill_full || fill_tmo || (m_xfer && ((state == S_HDR) || (state == S_DRAIN)));
  assign rd_addr = (state == S_FILL) ? '0 : pf;

  pcileech_eth_tx_aggr_ram #(
    .DEPTH (MAX_WORDS),
    .DW    (32)
  ) u_ram (
    .clk     (clk),
    .wr_en   (s_acc),
    .wr_addr (cnt[AW-1:0]),
    .wr_data (s_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      s_ready  <= 1'b0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_data   <= '0;
      cnt      <= '0;
      out_idx  <= '0;
      pf       <= '0;
      idle_cnt <= '0;
`ifdef PCILEECH_ETH_TX_AGGR_TRAILER_EN
      xacc     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          s_ready <= 1'b1;
          if (s_acc) begin
            state    <= S_FILL;
            cnt      <= CNT_W'(1);
            idle_cnt <= '0;
          end
        end

        S_FILL: begin
          if (s_acc) begin
            cnt      <= cnt_inc;
            idle_cnt <= '0;
            if (fill_full) begin
              state   <= S_HDR;
              s_ready <= 1'b0;
              m_valid <= 1'b1;
              m_data  <= make_hdr(HDR_MAGIC, cnt_inc);
              pf      <= AW'(1);
            end
          end else if (fill_tmo) begin
            state    <= S_HDR;
            s_ready  <= 1'b0;
            m_valid  <= 1'b1;
            m_data   <= make_hdr(HDR_MAGIC, cnt);
            pf       <= AW'(1);
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end

        S_HDR: begin
          if (m_ready) begin
            state   <= S_DRAIN;
            m_data  <= rd_q;
            m_last  <= !TRAILER_EN && (cnt == CNT_W'(1));
            out_idx <= '0;
            pf      <= pf + AW'(1);
`ifdef PCILEECH_ETH_TX_AGGR_TRAILER_EN
            xacc    <= m_data;
`endif
          end
        end

        S_DRAIN: begin
          if (m_ready) begin
            if (out_idx == cnt_dec) begin
`ifdef PCILEECH_ETH_TX_AGGR_TRAILER_EN
              state   <= S_TRAIL;
              m_data  <= xacc ^ m_data;
              m_last  <= 1'b1;
`else
              state   <= S_IDLE;
              s_ready <= 1'b1;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              cnt     <= '0;
`endif
            end else begin
              m_data  <= rd_q;
              m_last  <= !TRAILER_EN && (out_idx_inc == cnt_dec);
              out_idx <= out_idx_inc;
              pf      <= pf + AW'(1);
`ifdef PCILEECH_ETH_TX_AGGR_TRAILER_EN
              xacc    <= xacc ^ m_data;
`endif
            end
          end
        end

`ifdef PCILEECH_ETH_TX_AGGR_TRAILER_EN
        S_TRAIL: begin
          if (m_ready) begin
            state   <= S_IDLE;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            cnt     <= '0;
            xacc    <= '0;
          end
        end
`endif

        default: begin
          state   <= S_IDLE;
          s_ready <= 1'b0;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcileech_eth_tx_aggr.sv
// tb/tb_pcileech_eth_tx_aggr.sv - scoreboard bench for pcileech_eth_tx_aggr
// Trailer expectations follow PCILEECH_ETH_TX_AGGR_TRAILER_EN.
module tb_pcileech_eth_tx_aggr;

`ifdef PCILEECH_ETH_TX_AGGR_TRAILER_EN
  localparam bit TRAILER = 1'b1;
`else
  localparam bit TRAILER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  logic [32:0] exp_q[$];
  logic [31:0] words[$];
  bit          rand_ready = 1'b0;
  bit          ready_val  = 1'b1;
  bit          stalled    = 1'b0;
  logic [31:0] held;

  pcileech_eth_tx_aggr dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
  end

  // Output monitor: a transfer seen here completes on the following rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", 32'(m_valid), 1);
        check("hold_data", m_data, held);
      end
      if (m_valid) check("s_ready_low_while_out", 32'(s_ready), 0);
      if (m_valid && m_ready) begin
        logic [32:0] e;
        check("sb_has_entry", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("m_data", m_data, e[31:0]);
          check("m_last", 32'(m_last), 32'(e[32]));
        end
        n_out++;
      end
      stalled = m_valid && !m_ready;
      held    = m_data;
    end
  end

  task automatic push_expected();
    logic [31:0] hdr;
    logic [31:0] x;
    hdr = {16'hE7A0, 16'(words.size())};
    exp_q.push_back({1'b0, hdr});
    x = hdr;
    for (int i = 0; i < words.size(); i++) begin
      exp_q.push_back({(i == words.size() - 1) && !TRAILER, words[i]});
      x ^= words[i];
    end
    if (TRAILER) exp_q.push_back({1'b1, x});
  endtask

  task automatic send_word(input logic [31:0] w);
    bit acc;
    acc     = 1'b0;
    s_data  = w;
    s_valid = 1'b1;
    for (int k = 0; k < 2000 && !acc; k++) begin
      acc = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check("word_accepted", 32'(acc), 1);
  endtask

  task automatic send_all(input int gap);
    for (int i = 0; i < words.size(); i++) begin
      send_word(words[i]);
      if (gap > 1 && i != words.size() - 1) begin
        repeat (gap - 1) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_flush(input int expect_cycles);
    int k;
    k = 0;
    while (!m_valid && k < expect_cycles + 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("flush_latency", k, expect_cycles);
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && (exp_q.size() != 0 || busy); k++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", exp_q.size(), 0);
    check("idle_after_burst", 32'(busy), 0);
    check("s_ready_after_burst", 32'(s_ready), 1);
  endtask

  initial begin
    int target;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("s_ready_after_release", 32'(s_ready), 1);

    // Full burst of 256 back-to-back words
    words.delete();
    for (int i = 1; i <= 256; i++) words.push_back(32'(i));
    push_expected();
    send_all(0);
    check("full_s_ready_low", 32'(s_ready), 0);
    check("full_hdr_valid", 32'(m_valid), 1);
    check("full_busy", 32'(busy), 1);
    wait_drain(2000);

    // Three words then timeout flush
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back(32'hDEAD_0000 + 32'(i));
    push_expected();
    send_all(0);
    wait_flush(1000);
    wait_drain(200);

    // Ten words spaced 999 cycles apart: no early flush
    words.delete();
    for (int i = 0; i < 10; i++) words.push_back($urandom);
    push_expected();
    send_all(999);
    wait_flush(1000);
    wait_drain(200);

    // Random backpressure during drain
    words.delete();
    for (int i = 0; i < 24; i++) words.push_back($urandom);
    push_expected();
    rand_ready = 1'b1;
    send_all(0);
    wait_flush(1000);
    wait_drain(1000);
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of a drain, then a fresh burst
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back(32'h0000_0100 + 32'(i));
    push_expected();
    target = n_out + 4;
    send_all(0);
    for (int k = 0; k < 1200 && n_out < target; k++) begin
      @(posedge clk);
      #1;
    end
    check("mid_drain_reached", 32'(n_out >= target), 1);
    check("mid_drain_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("reset_m_valid_now", 32'(m_valid), 0);
    check("reset_m_last_now", 32'(m_last), 0);
    check("reset_busy_now", 32'(busy), 0);
    check("reset_s_ready_now", 32'(s_ready), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_s_ready", 32'(s_ready), 1);
    words.delete();
    for (int i = 0; i < 5; i++) words.push_back(32'h5A5A_0000 + 32'(i));
    push_expected();
    send_all(0);
    wait_flush(1000);
    wait_drain(200);

`ifdef PCILEECH_ETH_TX_AGGR_TRAILER_EN
    words.delete();
    words.push_back(32'h1);
    words.push_back(32'h2);
    words.push_back(32'h4);
    exp_q.push_back({1'b0, 32'hE7A0_0003});
    exp_q.push_back({1'b0, 32'h1});
    exp_q.push_back({1'b0, 32'h2});
    exp_q.push_back({1'b0, 32'h4});
    exp_q.push_back({1'b1, 32'hE7A0_0004});
    send_all(0);
    wait_flush(1000);
    wait_drain(200);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
